// File: rtl/vga_scanout.sv
// VGA timing generator with 1-bpp framebuffer scanout and integer upscaling.
// Define VGA_TEST_PATTERN_EN to add the test_pattern checkerboard input.
module vga_scanout #(
  parameter int          H_ACTIVE  = 640,
  parameter int          H_FP      = 16,
  parameter int          H_SYNC    = 96,
  parameter int          H_BP      = 48,
  parameter int          V_ACTIVE  = 480,
  parameter int          V_FP      = 10,
  parameter int          V_SYNC    = 2,
  parameter int          V_BP      = 33,
  parameter bit          SYNC_POL  = 1'b0,
  parameter int          FB_W      = 64,
  parameter int          FB_H      = 32,
  parameter int          X_SCALE   = 10,
  parameter int          Y_SCALE   = 15,
  parameter logic [11:0] FB_BASE   = 12'h000,
  parameter logic [11:0] FG_COLOUR = 12'hFFF,
  parameter logic [11:0] BG_COLOUR = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_tick,
  output logic        memory_read,
  output logic [11:0] memory_addr,
  input  logic [7:0]  memory_data,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        frame_start
`ifdef VGA_TEST_PATTERN_EN
  ,
  input  logic        test_pattern
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int XW = $clog2(X_SCALE + 1);
  localparam int YW = $clog2(Y_SCALE + 1);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [XW-1:0] XS_LAST = XW'(X_SCALE - 1);
  localparam logic [YW-1:0] YS_LAST = YW'(Y_SCALE - 1);

  // stage 0: raster position and framebuffer sub-counters
  logic [HW-1:0] h, fx;
  logic [VW-1:0] v, fy;
  logic [XW-1:0] xs;
  logic [YW-1:0] ys;

  logic          h_last, v_last;
  logic          act0, hit0, hs0, vs0, fs0;
  logic [11:0]   addr0;
  logic [2:0]    bit0;

  always_comb begin
    h_last = (h == H_LAST);
    v_last = (v == V_LAST);
    act0   = (32'(h) < H_ACTIVE) && (32'(v) < V_ACTIVE);
    hit0   = act0 && (32'(fx) < FB_W) && (32'(fy) < FB_H);
    hs0    = (32'(h) >= H_ACTIVE + H_FP)
          && (32'(h) <  H_ACTIVE + H_FP + H_SYNC);
    vs0    = (32'(v) >= V_ACTIVE + V_FP)
          && (32'(v) <  V_ACTIVE + V_FP + V_SYNC);
    fs0    = (h == '0) && (v == '0);
    addr0  = FB_BASE
           + 12'(32'(fy) * (FB_W / 8))
           + 12'(32'(fx) >> 3);
    bit0   = ~fx[2:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h  <= '0;
      v  <= '0;
      xs <= '0;
      fx <= '0;
      ys <= '0;
      fy <= '0;
    end else if (pix_tick) begin
      if (h_last) begin
        h  <= '0;
        xs <= '0;
        fx <= '0;
        if (v_last) begin
          v  <= '0;
          ys <= '0;
          fy <= '0;
        end else begin
          v <= v + VW'(1);
          if (ys == YS_LAST) begin
            ys <= '0;
            fy <= fy + VW'(1);
          end else begin
            ys <= ys + YW'(1);
          end
        end
      end else begin
        h <= h + HW'(1);
        if (xs == XS_LAST) begin
          xs <= '0;
          fx <= fx + HW'(1);
        end else begin
          xs <= xs + XW'(1);
        end
      end
    end
  end

  // stage 1: memory request plus sideband carried alongside it
  logic       act1, hit1, hs1, vs1, fs1;
  logic [2:0] bit1;
  logic       tp1, tpp1;
  logic       tp_sel, rd0;

`ifdef VGA_TEST_PATTERN_EN
  assign tp_sel = test_pattern;
`else
  assign tp_sel = 1'b0;
`endif
  assign rd0 = hit0 && !tp_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      memory_read <= 1'b0;
      memory_addr <= FB_BASE;
      bit1        <= 3'd0;
      act1        <= 1'b0;
      hit1        <= 1'b0;
      hs1         <= 1'b0;
      vs1         <= 1'b0;
      fs1         <= 1'b0;
      tp1         <= 1'b0;
      tpp1        <= 1'b0;
    end else if (pix_tick) begin
      memory_read <= rd0;
      memory_addr <= addr0;
      bit1        <= bit0;
      act1        <= act0;
      hit1        <= hit0;
      hs1         <= hs0;
      vs1         <= vs0;
      fs1         <= fs0;
      tp1         <= tp_sel;
      tpp1        <= fx[0] ^ fy[0];
    end
  end

  // stage 2: colour and sync to the pins
  logic        pix2;
  logic [11:0] col2;
  logic [11:0] rgb;

  always_comb begin
    pix2 = hit1 && (tp1 ? tpp1 : memory_data[bit1]);
    col2 = 12'h000;
    if (act1) col2 = pix2 ? FG_COLOUR : BG_COLOUR;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb         <= 12'h000;
      vga_hsync   <= !SYNC_POL;
      vga_vsync   <= !SYNC_POL;
      frame_start <= 1'b0;
    end else if (pix_tick) begin
      rgb         <= col2;
      vga_hsync   <= hs1 ? SYNC_POL : !SYNC_POL;
      vga_vsync   <= vs1 ? SYNC_POL : !SYNC_POL;
      frame_start <= fs1;
    end else begin
      frame_start <= 1'b0;
    end
  end

  assign vga_r = rgb[11:8];
  assign vga_g = rgb[7:4];
  assign vga_b = rgb[3:0];

endmodule

// File: tb/tb_vga_scanout.sv
// Randomised bench for vga_scanout using a scaled-down raster so that
// several whole frames fit in a short run.
module tb_vga_scanout;

  localparam int HA = 36, HFP = 2, HSY = 3, HBP = 3;
  localparam int VA = 10, VFP = 1, VSY = 2, VBP = 2;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FBW = 16, FBH = 4, XS = 2, YS = 2;
  localparam bit POL = 1'b0;
  localparam logic [11:0] BASE = 12'hFFC;
  localparam logic [11:0] FG = 12'hA5C;
  localparam logic [11:0] BG = 12'h312;

  typedef struct packed {
    logic        rd;
    logic [11:0] addr;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        fs;
  } exp_t;

  logic        clk, rst, pix_tick;
  logic        memory_read;
  logic [11:0] memory_addr;
  logic [7:0]  memory_data;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hsync, vga_vsync, frame_start;
  logic        test_pattern;

  logic [7:0]  mem [4096];
  int          vectors, miscompares, tick_n;

  assign memory_data = memory_read ? mem[memory_addr] : 8'hFF;

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .SYNC_POL(POL), .FB_W(FBW), .FB_H(FBH),
    .X_SCALE(XS), .Y_SCALE(YS), .FB_BASE(BASE),
    .FG_COLOUR(FG), .BG_COLOUR(BG)
  ) dut (
    .clk(clk), .rst(rst), .pix_tick(pix_tick),
    .memory_read(memory_read), .memory_addr(memory_addr),
    .memory_data(memory_data),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .frame_start(frame_start)
`ifdef VGA_TEST_PATTERN_EN
    ,
    .test_pattern(test_pattern)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected outputs after n ticks since reset: stage 1 shows raster
  // position n-1, the pins show position n-2
  function automatic exp_t model(int n, bit tp, bit idle);
    exp_t e;
    int p, h, v, fx, fy, a;
    bit hit, act, pix;
    e = '0;
    e.hs = ~POL;
    e.vs = ~POL;
    if (n >= 1) begin
      p = n - 1;
      h = p % HT; v = (p / HT) % VT;
      fx = h / XS; fy = v / YS;
      hit = h < HA && v < VA && fx < FBW && fy < FBH;
      e.rd = hit && !tp;
      if (e.rd) e.addr = 12'(int'(BASE) + fy * (FBW / 8) + fx / 8);
    end
    if (n >= 2) begin
      p = n - 2;
      h = p % HT; v = (p / HT) % VT;
      fx = h / XS; fy = v / YS;
      act = h < HA && v < VA;
      hit = act && fx < FBW && fy < FBH;
      if (act) begin
        a = (int'(BASE) + fy * (FBW / 8) + fx / 8) % 4096;
        if (!hit) pix = 1'b0;
        else if (tp) pix = ((fx ^ fy) & 1) != 0;
        else pix = mem[a][7 - (fx % 8)];
        e.rgb = pix ? FG : BG;
      end
      e.hs = (h >= HA + HFP && h < HA + HFP + HSY) ? POL : ~POL;
      e.vs = (v >= VA + VFP && v < VA + VFP + VSY) ? POL : ~POL;
      e.fs = !idle && h == 0 && v == 0;
    end
    return e;
  endfunction

  function automatic exp_t obs();
    exp_t o;
    o.rd   = memory_read;
    o.addr = memory_read ? memory_addr : 12'h000;
    o.rgb  = {vga_r, vga_g, vga_b};
    o.hs   = vga_hsync;
    o.vs   = vga_vsync;
    o.fs   = frame_start;
    return o;
  endfunction

  task automatic reset_dut();
    pix_tick = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick_n = 0;
  endtask

  task automatic do_tick();
    pix_tick = 1'b1;
    @(negedge clk);
    pix_tick = 1'b0;
    tick_n++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pix_tick = 1'b1;
    repeat (3) @(negedge clk);
    vectors += 6;
    if (memory_read !== 1'b0) begin
      miscompares++; $display("FAIL reset_read got %b want 0", memory_read);
    end
    if (memory_addr !== BASE) begin
      miscompares++; $display("FAIL reset_addr got %h want %h", memory_addr, BASE);
    end
    if ({vga_r, vga_g, vga_b} !== 12'h000) begin
      miscompares++; $display("FAIL reset_rgb got %h want 000", {vga_r, vga_g, vga_b});
    end
    if (vga_hsync !== ~POL) begin
      miscompares++; $display("FAIL reset_hsync got %b want %b", vga_hsync, ~POL);
    end
    if (vga_vsync !== ~POL) begin
      miscompares++; $display("FAIL reset_vsync got %b want %b", vga_vsync, ~POL);
    end
    if (frame_start !== 1'b0) begin
      miscompares++; $display("FAIL reset_fs got %b want 0", frame_start);
    end
    reset_dut();
  endtask

  task automatic test_frame();
    exp_t e, o;
    int first_fs, gap;
    first_fs = -1;
    reset_dut();
    for (int i = 0; i < 2 * HT * VT + 4; i++) begin
      do_tick();
      o = obs(); e = model(tick_n, 1'b0, 1'b0);
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL frame tick %0d got %h want %h", tick_n, o, e);
      end
      if (o.fs === 1'b1) begin
        if (first_fs >= 0) begin
          vectors++;
          if (tick_n - first_fs != HT * VT) begin
            miscompares++;
            $display("FAIL fs_period got %0d want %0d", tick_n - first_fs, HT * VT);
          end
        end
        first_fs = tick_n;
      end
      gap = $urandom_range(1, 4);
      repeat (gap) begin
        @(negedge clk);
        o = obs(); e = model(tick_n, 1'b0, 1'b1);
        vectors++;
        if (o !== e) begin
          miscompares++;
          $display("FAIL frame_idle tick %0d got %h want %h", tick_n, o, e);
        end
      end
    end
    vectors++;
    if (first_fs < 0) begin
      miscompares++; $display("FAIL fs_seen got none want pulse");
    end
  endtask

  task automatic test_mid_reset();
    exp_t e, o;
    reset_dut();
    while (tick_n < 5 * HT + 10 + 2) begin
      do_tick();
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    o = obs();
    vectors += 2;
    if (o !== model(0, 1'b0, 1'b1)) begin
      miscompares++; $display("FAIL midrst_out got %h want %h", o, model(0, 1'b0, 1'b1));
    end
    if (memory_addr !== BASE) begin
      miscompares++; $display("FAIL midrst_addr got %h want %h", memory_addr, BASE);
    end
    @(negedge clk);
    rst = 1'b0;
    tick_n = 0;
    for (int i = 0; i < 2 * HT + 5; i++) begin
      do_tick();
      o = obs(); e = model(tick_n, 1'b0, 1'b0);
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL midrst_run tick %0d got %h want %h", tick_n, o, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    exp_t e, o;
    reset_dut();
    while (tick_n < 3 * HT + 20) begin
      do_tick();
      @(negedge clk);
    end
    for (int i = 0; i < 50; i++) begin
      o = obs(); e = model(tick_n, 1'b0, 1'b1);
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL stall clk %0d got %h want %h", i, o, e);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 2 * HT; i++) begin
      do_tick();
      o = obs(); e = model(tick_n, 1'b0, 1'b0);
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL stall_resume tick %0d got %h want %h", tick_n, o, e);
      end
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e, o;
    reset_dut();
    pix_tick = 1'b1;
    for (int i = 0; i < HT * VT + 2 * HT; i++) begin
      @(negedge clk);
      tick_n++;
      o = obs(); e = model(tick_n, 1'b0, 1'b0);
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL b2b tick %0d got %h want %h", tick_n, o, e);
      end
    end
    pix_tick = 1'b0;
    @(negedge clk);
  endtask

`ifdef VGA_TEST_PATTERN_EN
  task automatic test_pattern_mode();
    exp_t e, o;
    reset_dut();
    test_pattern = 1'b1;
    for (int i = 0; i < HT * VT + 4; i++) begin
      do_tick();
      o = obs(); e = model(tick_n, 1'b1, 1'b0);
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL pattern tick %0d got %h want %h", tick_n, o, e);
      end
      @(negedge clk);
    end
    test_pattern = 1'b0;
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    tick_n = 0;
    rst = 1'b1;
    pix_tick = 1'b0;
    test_pattern = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    @(negedge clk);
    test_reset();
    test_frame();
    test_mid_reset();
    test_stall();
    test_back_to_back();
`ifdef VGA_TEST_PATTERN_EN
    test_pattern_mode();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
